// File: rtl/reg_bank.sv
// Byte-enabled register bank with one-cycle registered reads and a multi-cycle
// clear sweep that walks every entry back to RESET_VAL.
module reg_bank #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int ADDR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1,
  localparam int BE_W = WIDTH / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [BE_W-1:0]   be,
  input  logic              clr,
  output logic [WIDTH-1:0]  rdata,
  output logic              rvalid,
  output logic              err,
  output logic              busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic              rvalid_q, err_q;
  logic              inRange, accept, reject;

  // clr takes priority over any access presented in the same cycle
  assign inRange = ({1'b0, addr} < DEPTH_C);
  assign accept  = sel && (state_q == IDLE) && !clr && inRange;
  assign reject  = sel && !accept;

  always_comb begin
    rdata_d = '0;
    if (accept && !wr) rdata_d = mem_q[addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= accept && !wr;
      err_q    <= reject;
      case (state_q)
        IDLE: begin
          if (clr) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
          end
        end
        CLEAR: begin
          if (ptr_q == LAST_C) state_q <= IDLE;
          else ptr_q <= ptr_q + ADDR_W'(1);
        end
      endcase
    end
  end

  // Sweep writes and accesses never coincide because accesses need state IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
    end else if (state_q == CLEAR) begin
      mem_q[ptr_q] <= RESET_VAL;
    end else if (accept && wr) begin
      for (int b = 0; b < BE_W; b++)
        if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;
  assign busy   = (state_q == CLEAR);

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: stimulus pushes expected responses, a negedge
// monitor pops them in the exact cycle they are due and flags stray pulses.
module tb_reg_bank;

  typedef struct {
    logic        isErr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic sel8 = 0, wr8 = 0, clr8 = 0;
  logic [2:0] addr8 = '0;
  logic [15:0] wdata8 = '0;
  logic [1:0] be8 = '0;
  logic [15:0] rdata8;
  logic rvalid8, err8, busy8;

  logic sel5 = 0, wr5 = 0, clr5 = 0;
  logic [2:0] addr5 = '0;
  logic [15:0] wdata5 = '0;
  logic [1:0] be5 = '0;
  logic [15:0] rdata5;
  logic rvalid5, err5, busy5;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int run = 0;
  int lastRun = 0;
  exp_t q8[$];
  exp_t q5[$];

  reg_bank u_dut8 (
    .clk(clk), .rst(rst), .sel(sel8), .wr(wr8), .addr(addr8), .wdata(wdata8),
    .be(be8), .clr(clr8), .rdata(rdata8), .rvalid(rvalid8), .err(err8), .busy(busy8)
  );

  reg_bank #(.DEPTH(5)) u_dut5 (
    .clk(clk), .rst(rst), .sel(sel5), .wr(wr5), .addr(addr5), .wdata(wdata5),
    .be(be5), .clr(clr5), .rdata(rdata5), .rvalid(rvalid5), .err(err5), .busy(busy5)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy8) run++;
    else if (run != 0) begin
      lastRun = run;
      run = 0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  task automatic monitorOne(input int inst, input logic rv, input logic er, input logic [15:0] rd);
    exp_t e;
    logic have;
    string tag;
    have = 1'b0;
    tag = (inst == 0) ? "8" : "5";
    if (inst == 0) begin
      if (q8.size() > 0 && q8[0].cyc + 1 == cyc) begin
        e = q8.pop_front();
        have = 1'b1;
      end
    end else begin
      if (q5.size() > 0 && q5[0].cyc + 1 == cyc) begin
        e = q5.pop_front();
        have = 1'b1;
      end
    end
    if (have)
      checkOutput({"resp", tag}, {14'b0, rv, er, rd}, {14'b0, !e.isErr, e.isErr, e.data});
    else if (rv || er)
      checkOutput({"spurious", tag}, {14'b0, rv, er, rd}, 32'b0);
    if (!rv) checkOutput({"idleRdata", tag}, {16'b0, rd}, 32'b0);
  endtask

  always @(negedge clk) begin
    monitorOne(0, rvalid8, err8, rdata8);
    monitorOne(1, rvalid5, err5, rdata5);
  end

  // kind: 0 = no response, 1 = read data, 2 = err pulse
  task automatic applyStimulus(input int inst, input logic s, input logic w, input logic [2:0] a,
                               input logic [15:0] d, input logic [1:0] b, input logic c,
                               input int kind, input logic [15:0] expData);
    exp_t e;
    if (inst == 0) begin
      sel8 = s; wr8 = w; addr8 = a; wdata8 = d; be8 = b; clr8 = c;
    end else begin
      sel5 = s; wr5 = w; addr5 = a; wdata5 = d; be5 = b; clr5 = c;
    end
    if (kind != 0) begin
      e.isErr = (kind == 2);
      e.data = (kind == 2) ? 16'h0000 : expData;
      e.cyc = cyc;
      if (inst == 0) q8.push_back(e);
      else q5.push_back(e);
    end
    @(posedge clk);
    #1;
    sel8 = 0; wr8 = 0; clr8 = 0; be8 = '0;
    sel5 = 0; wr5 = 0; clr5 = 0; be5 = '0;
  endtask

  task automatic doWrite(input int inst, input logic [2:0] a, input logic [15:0] d, input logic [1:0] b);
    applyStimulus(inst, 1, 1, a, d, b, 0, 0, 16'h0);
  endtask

  task automatic doRead(input int inst, input logic [2:0] a, input logic [15:0] expData);
    applyStimulus(inst, 1, 0, a, 16'h0, 2'b00, 0, 1, expData);
  endtask

  task automatic waitSweepDone();
    int n;
    n = 0;
    while (busy8 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("busyTimeout", {31'b0, busy8}, 32'b0);
    @(negedge clk);
    #1;
    checkOutput("busyLength", lastRun, 8);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    checkOutput("rstRdata", {16'b0, rdata8}, 32'b0);
    checkOutput("rstRvalid", {31'b0, rvalid8}, 32'b0);
    checkOutput("rstErr", {31'b0, err8}, 32'b0);
    checkOutput("rstBusy", {31'b0, busy8}, 32'b0);

    for (int i = 0; i < 8; i++) doRead(0, 3'(i), 16'h0000);

    doWrite(0, 3, 16'hABCD, 2'b11);
    doWrite(0, 3, 16'h1234, 2'b01);
    doRead(0, 3, 16'hAB34);
    doWrite(0, 2, 16'h5A5A, 2'b11);
    doRead(0, 2, 16'h5A5A);
    doWrite(0, 2, 16'hFFFF, 2'b00);
    doRead(0, 2, 16'h5A5A);
    doWrite(0, 2, 16'h00C3, 2'b10);
    doRead(0, 2, 16'h005A);
    applyStimulus(0, 0, 1, 2, 16'hEEEE, 2'b11, 0, 0, 16'h0);
    doRead(0, 2, 16'h005A);

    // Clear sweep: read just before clr sees old data, clr+sel is rejected
    for (int i = 0; i < 8; i++) doWrite(0, 3'(i), 16'h1100 + 16'(i), 2'b11);
    doRead(0, 5, 16'h1105);
    applyStimulus(0, 1, 0, 1, 16'h0, 2'b00, 1, 2, 16'h0);
    checkOutput("busyStart", {31'b0, busy8}, 32'b1);
    doRead(0, 0, 16'h0);
    q8[$].isErr = 1'b1;
    q8[$].data = 16'h0;
    applyStimulus(0, 0, 0, 0, 16'h0, 2'b00, 1, 0, 16'h0);
    waitSweepDone();
    for (int i = 0; i < 8; i++) doRead(0, 3'(i), 16'h0000);

    // Reset in the middle of a sweep, with an access presented during reset
    for (int i = 4; i < 8; i++) doWrite(0, 3'(i), 16'hC0D0 + 16'(i), 2'b11);
    applyStimulus(0, 0, 0, 0, 16'h0, 2'b00, 1, 0, 16'h0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput("busyMidSweep", {31'b0, busy8}, 32'b1);
    rst = 1;
    sel8 = 1; wr8 = 1; addr8 = 6; wdata8 = 16'hFFFF; be8 = 2'b11;
    #1;
    checkOutput("busyAsyncRst", {31'b0, busy8}, 32'b0);
    @(posedge clk);
    #1;
    rst = 0;
    sel8 = 0; wr8 = 0; be8 = '0;
    for (int i = 0; i < 8; i++) doRead(0, 3'(i), 16'h0000);
    doWrite(0, 6, 16'h7777, 2'b11);
    doRead(0, 6, 16'h7777);

    // Out-of-range addresses on the DEPTH=5 instance
    doWrite(1, 4, 16'h1111, 2'b11);
    applyStimulus(1, 1, 0, 6, 16'h0, 2'b00, 0, 2, 16'h0);
    applyStimulus(1, 1, 1, 7, 16'h2222, 2'b11, 0, 2, 16'h0);
    applyStimulus(1, 1, 1, 5, 16'h3333, 2'b11, 0, 2, 16'h0);
    doRead(1, 4, 16'h1111);
    doRead(1, 0, 16'h0000);
    doRead(1, 1, 16'h0000);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("pending8", q8.size(), 0);
    checkOutput("pending5", q5.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
